// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM states, access-length codes and the stall/select buses shared with the pipeline.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef struct packed {
        logic if_stall;
        logic mem_stall;
    } stall_bus_t;

    typedef enum logic {SEL_IF, SEL_MEM} mem_sel_t;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        return len == LEN_BYTE ? 3'd1 : len == LEN_HALF ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM requests onto a byte-wide RAM, serialising little-endian accesses.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [1:0]        mem_len,
    input  logic              mem_extend,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    state_t     state;
    mem_sel_t   sel;
    logic [1:0] len_q;
    logic       ext_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic [2:0]  cnt;
    logic [2:0]  n;
    logic [31:0] load_val;
    stall_bus_t  stall;

    assign n            = len_bytes(len_q);
    assign stall        = {if_req & ~if_done, mem_req & ~mem_done};
    assign stallreq_if  = stall.if_stall;
    assign stallreq_mem = stall.mem_stall;

    // IF fetches are latched as word length, so they never get extended
    always_comb begin
        load_val = len_q[1] ? data_q :
                   len_q == LEN_HALF ? {{16{ext_q & data_q[15]}}, data_q[15:0]} :
                   {{24{ext_q & data_q[7]}}, data_q[7:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sel       <= SEL_IF;
            len_q     <= LEN_BYTE;
            ext_q     <= 1'b0;
            wdata_q   <= '0;
            data_q    <= '0;
            cnt       <= '0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            ram_wr    <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_req || if_req) begin
                    sel      <= mem_req ? SEL_MEM : SEL_IF;
                    ram_addr <= mem_req ? mem_addr : if_addr;
                    len_q    <= mem_req ? mem_len : LEN_WORD;
                    ext_q    <= mem_extend;
                    cnt      <= '0;
                    data_q   <= '0;
                    ram_wr   <= mem_req && mem_we;
                    ram_dout <= mem_wdata[7:0];
                    wdata_q  <= mem_wdata >> 8;
                    state    <= mem_req && mem_we ? WRITE : READ;
                end
                // ram_din carries the byte addressed in the previous cycle
                READ: if (cnt < n) begin
                    data_q[{cnt[1:0], 3'b000} +: 8] <= ram_din;
                    cnt <= cnt + 3'd1;
                    if (cnt + 3'd1 < n) ram_addr <= ram_addr + ADDR_W'(1);
                end else begin
                    state <= DONE;
                    if (sel == SEL_IF) begin
                        if_rdata <= load_val;
                        if_done  <= 1'b1;
                    end else begin
                        mem_rdata <= load_val;
                        mem_done  <= 1'b1;
                    end
                end
                WRITE: if (cnt + 3'd1 < n) begin
                    cnt      <= cnt + 3'd1;
                    ram_addr <= ram_addr + ADDR_W'(1);
                    ram_dout <= wdata_q[7:0];
                    wdata_q  <= wdata_q >> 8;
                end else begin
                    ram_wr   <= 1'b0;
                    mem_done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random accesses checked against a byte-array model of RAM contents.
module tb_mem_ctrl;

    logic        clk, rst;
    logic        if_req, if_done, mem_req, mem_we, mem_extend, mem_done, ram_wr;
    logic        stallreq_if, stallreq_mem;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, ram_addr;
    logic [1:0]  mem_len;
    logic [7:0]  ram_dout, ram_din;

    logic [7:0] bram [256];
    logic [7:0] ref_mem [256];
    logic       ld_en;
    logic [7:0] ld_a, ld_d;

    int vectors = 0;
    int errors  = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_len(mem_len), .mem_extend(mem_extend), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // 256-byte RAM aliased over the full address space; read data is combinational on the address
    assign ram_din = bram[ram_addr[7:0]];
    always @(posedge clk) begin
        if (ld_en) bram[ld_a] <= ld_d;
        else if (ram_wr) bram[ram_addr[7:0]] <= ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n, input bit ext);
        logic [31:0] v = 0;
        logic [31:0] t;
        for (int k = 0; k < n; k++) begin
            t = a + 32'(k);
            v = v + (32'(ref_mem[t[7:0]]) << (8 * k));
        end
        if (ext && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic access(input bit is_if, input bit we, input logic [31:0] a, input logic [1:0] len,
                          input logic [31:0] wd, input bit ext, input bit drop);
        int n = is_if ? 4 : (len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4);
        bit wr = !is_if && we;
        int lat = wr ? n + 1 : n + 2;
        logic [31:0] exp = ref_read(a, n, ext && !is_if);
        logic [31:0] t;
        int cyc = 0;
        if (is_if) begin
            if_req = 1; if_addr = a;
        end else begin
            mem_req = 1; mem_we = we; mem_addr = a; mem_len = len; mem_wdata = wd; mem_extend = ext;
        end
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc - 1 < n) begin
                chk("ram_addr", ram_addr, a + 32'(cyc - 1));
                chk("ram_wr", {31'd0, ram_wr}, {31'd0, wr});
                if (wr) chk("ram_dout", {24'd0, ram_dout}, (wd >> (8 * (cyc - 1))) & 32'hFF);
            end else chk("ram_wr_idle", {31'd0, ram_wr}, 32'd0);
            chk("stall_if", {31'd0, stallreq_if}, {31'd0, if_req & ~if_done});
            chk("stall_mem", {31'd0, stallreq_mem}, {31'd0, mem_req & ~mem_done});
            chk("done_excl", {31'd0, if_done & mem_done}, 32'd0);
            if (if_done || mem_done) break;
            if (drop && cyc == 2) begin
                if_req = 0; mem_req = 0;
            end
        end
        chk("latency", cyc, lat);
        chk("if_done", {31'd0, if_done}, {31'd0, is_if});
        chk("mem_done", {31'd0, mem_done}, {31'd0, !is_if});
        if (is_if) chk("if_rdata", if_rdata, exp);
        else if (!we) chk("mem_rdata", mem_rdata, exp);
        if (wr) for (int k = 0; k < n; k++) begin
            t = a + 32'(k);
            ref_mem[t[7:0]] = 8'((wd >> (8 * k)) & 32'hFF);
        end
        if_req = 0; mem_req = 0;
        @(negedge clk);
        chk("done_pulse", {30'd0, if_done, mem_done}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] wd;
        rst = 0; ld_en = 0; ld_a = 0; ld_d = 0;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
        mem_wdata = 0; mem_len = 0; mem_extend = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ld_en = 1; ld_a = 8'(i);
            ld_d = i < 4 ? 8'(8'h11 * (i + 1)) : i == 7 ? 8'h80 : 8'($urandom);
            ref_mem[i] = ld_d;
        end
        @(negedge clk);
        ld_en = 0;
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_dones", {30'd0, if_done, mem_done}, 0);
        rst = 1;
        @(negedge clk);

        access(0, 0, 32'h100, 2'b10, 0, 0, 0);
        chk("word_load_value", mem_rdata, 32'h44332211);
        access(0, 0, 32'h7, 2'b00, 0, 1, 0);
        chk("byte_sext", mem_rdata, 32'hFFFFFF80);
        access(0, 0, 32'h7, 2'b00, 0, 0, 0);
        chk("byte_zext", mem_rdata, 32'h00000080);
        access(0, 1, 32'h20, 2'b01, 32'hA5B6C7D8, 0, 0);
        access(0, 0, 32'h20, 2'b01, 0, 0, 0);
        chk("half_readback", mem_rdata, 32'h0000C7D8);
        access(0, 0, 32'hFFFFFFFE, 2'b10, 0, 0, 0);
        access(1, 0, 32'h103, 2'b00, 0, 0, 0);

        // simultaneous requests: MEM first, IF right after the return to IDLE
        mem_req = 1; mem_we = 0; mem_addr = 32'h10; mem_len = 2'b10; mem_extend = 0;
        if_req = 1; if_addr = 32'h30;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            chk("arb_if_wait", {31'd0, if_done}, 0);
            if (mem_done) break;
        end
        chk("arb_mem_lat", cyc, 6);
        chk("arb_mem_rdata", mem_rdata, ref_read(32'h10, 4, 0));
        mem_req = 0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            chk("arb_mem_quiet", {31'd0, mem_done}, 0);
            if (if_done) break;
        end
        chk("arb_if_lat", cyc, 7);
        chk("arb_if_rdata", if_rdata, ref_read(32'h30, 4, 0));
        if_req = 0;
        @(negedge clk);

        // reset during the second byte of a word store
        wd = $urandom;
        mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_len = 2'b10; mem_wdata = wd;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_addr", ram_addr, 32'h41);
        rst = 0;
        #1;
        chk("async_ram_wr", {31'd0, ram_wr}, 0);
        chk("async_ram_addr", ram_addr, 0);
        chk("async_done", {31'd0, mem_done}, 0);
        ref_mem[8'h40] = wd[7:0];
        mem_req = 0;
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'd0, mem_done, ram_wr}, 0);
        end
        access(0, 0, 32'h40, 2'b10, 0, 0, 0);

        for (int i = 0; i < 40; i++)
            access($urandom_range(0, 3) == 0, 1'($urandom), $urandom, 2'($urandom), $urandom,
                   1'($urandom), $urandom_range(0, 3) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, giving the width of every address port.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port if_req, input, 1 bit: instruction fetch request, held until if_done.
REQ-005 SHALL have port if_addr, input, ADDR_W bits: fetch address.
REQ-006 SHALL have port if_rdata, output, 32 bits: fetched word, valid while if_done=1.
REQ-007 SHALL have port if_done, output, 1 bit: one-cycle fetch completion pulse.
REQ-008 SHALL have port mem_req, input, 1 bit: MEM-stage access request, held until mem_done.
REQ-009 SHALL have port mem_we, input, 1 bit: 1 = store, 0 = load.
REQ-010 SHALL have port mem_addr, input, ADDR_W bits: MEM-stage access address.
REQ-011 SHALL have port mem_wdata, input, 32 bits: store data.
REQ-012 SHALL have port mem_len, input, 2 bits: access size; 00 = byte, 01 = half, 10 = word, 11 = word.
REQ-013 SHALL have port mem_extend, input, 1 bit: 1 = sign-extend loads, 0 = zero-extend.
REQ-014 SHALL have port mem_rdata, output, 32 bits: load result, valid while mem_done=1.
REQ-015 SHALL have port mem_done, output, 1 bit: one-cycle completion pulse for the MEM-stage access.
REQ-016 SHALL have port ram_addr, output, ADDR_W bits: byte address to the RAM.
REQ-017 SHALL have port ram_dout, output, 8 bits: write byte to the RAM.
REQ-018 SHALL have port ram_wr, output, 1 bit: RAM write strobe.
REQ-019 SHALL have port ram_din, input, 8 bits: RAM read byte, valid one cycle after the address.
REQ-020 SHALL have port stallreq_if, output, 1 bit: combinational, equal to if_req & ~if_done.
REQ-021 SHALL have port stallreq_mem, output, 1 bit: combinational, equal to mem_req & ~mem_done.

Function
REQ-022 SHALL implement FSM states IDLE, READ, WRITE and DONE; only IDLE samples requests.
REQ-023 In IDLE, if mem_req=1 the controller SHALL grant MEM (go to WRITE if mem_we=1, else READ) before IF; otherwise, if if_req=1, it SHALL grant IF as a 4-byte READ.
REQ-024 The grant edge E0 SHALL latch the op, address, length (n = 1, 2 or 4 bytes), data and extend flag, and SHALL drive ram_addr = addr.
REQ-025 After the grant, a later mem_req SHALL NOT preempt an IF access in flight; mem_req SHALL wait for the return to IDLE.
REQ-026 READ: ram_addr SHALL equal addr+k after edge Ek (k = 0..n-1), and byte k SHALL be captured from ram_din at edge E(k+1).
REQ-027 READ: assembly SHALL be little-endian; the result SHALL appear with done = 1 in the cycle after E(n+1)... specifically done SHALL be set at edge E n+1... (see REQ-028).
REQ-028 READ completion: at edge E n+1, the assembled word SHALL be registered onto the rdata output of the requester and the matching done SHALL go high for exactly one cycle (DONE state).
REQ-029 Load extension: byte and half loads SHALL be sign- or zero-extended per mem_extend; word loads and IF fetches SHALL be unaffected.
REQ-030 WRITE: after edge Ek (k = 0..n-1), outputs SHALL be ram_wr = 1, ram_addr = addr+k and ram_dout = wdata[8k+7:8k].
REQ-031 WRITE completion: at edge En, ram_wr SHALL be 0 and mem_done SHALL be 1 for one cycle.
REQ-032 DONE SHALL return to IDLE on the next edge and SHALL ignore all requests.
REQ-033 Address increments SHALL wrap modulo 2^ADDR_W; misaligned addresses SHALL be legal.
REQ-034 If a requester drops its req mid-access, the access SHALL still complete and the done pulse SHALL still fire.
REQ-035 ram_wr SHALL be 0 in IDLE, READ and DONE.
REQ-036 if_done and mem_done SHALL never be high in the same cycle.

Reset
REQ-037 rst=0 SHALL immediately (asynchronously) force state IDLE and zero every output register: ram_addr, ram_dout, ram_wr, if_rdata, mem_rdata, if_done, mem_done.
REQ-038 If reset occurs mid-access, the aborted access SHALL produce no done pulse and no further RAM write.

Structure
REQ-039 State encodings and the mem_len codes SHALL live in the shared defines file beside the StallBus and MemSelBus definitions.
REQ-040 The design SHALL be a single module; no sub-module SHALL be instantiated.

Verification
REQ-041 Word load from 0x100 with RAM bytes 11,22,33,44 -> mem_rdata=0x44332211, mem_done high exactly 5 cycles after E0.
REQ-042 Byte load from 0x7 with RAM byte 0x80: mem_extend=1 -> 0xFFFFFF80; mem_extend=0 -> 0x00000080.
REQ-043 Half store of 0xA5B6C7D8 to 0x20 -> 2 write cycles writing D8 at 0x20 and C7 at 0x21; mem_done follows 2 cycles after E0.
REQ-044 if_req and mem_req rise in the same IDLE cycle -> MEM granted first; IF is granted in the IDLE cycle after mem_done.
REQ-045 Word load at 0xFFFFFFFE -> RAM addresses FFFFFFFE, FFFFFFFF, 0, 1 in that order.
REQ-046 Reset asserted on the 2nd byte of a word store -> ram_wr=0 immediately, no mem_done, IDLE after release.
